// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for an MCP4921-style 12-bit DAC: one 16-bit frame per accepted sample.
// Optional DAC_SPI_TX_LDAC_EN adds an active-low ldac pulse (LATCH state) after each frame.
module dac_spi_tx #(
   parameter int unsigned CLK_DIV = 4,
   parameter bit          BUF     = 1'b0,
   parameter bit          GAIN1X  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] data_in,
   output logic        ready,
   output logic        done,
   output logic        sck,
   output logic        sdo,
   output logic        chip_en
`ifdef DAC_SPI_TX_LDAC_EN
   ,
   output logic        ldac
`endif
);

   localparam int unsigned PW      = 8;
   localparam int unsigned BW      = 4;
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_PRE  = PW'(CLK_DIV - 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(15);
   localparam bit ONE_CYC = (CLK_DIV == 32'd1);
`ifdef DAC_SPI_TX_LDAC_EN
   localparam bit HAS_LATCH = 1'b1;
`else
   localparam bit HAS_LATCH = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_GAP,
      S_LATCH
   } state_t;

   state_t          state;
   logic [PW-1:0]   phase;
   logic [BW-1:0]   bit_cnt;
   logic [14:0]     shreg;
   logic [15:0]     frame_word_c;

   // Channel A, buffer, gain, active (SHDN_n=1), then the 12-bit code.
   assign frame_word_c = {1'b0, BUF, GAIN1X, 1'b1, data_in};

   // Frame sequencer; every pin comes straight from a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         sck     <= 1'b0;
         sdo     <= 1'b0;
         chip_en <= 1'b1;
         phase   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
`ifdef DAC_SPI_TX_LDAC_EN
         ldac    <= 1'b1;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_SETUP;
                  ready   <= 1'b0;
                  chip_en <= 1'b0;
                  sck     <= 1'b0;
                  sdo     <= frame_word_c[15];
                  shreg   <= frame_word_c[14:0];
                  phase   <= '0;
                  bit_cnt <= '0;
               end
            end

            S_SETUP: begin
               if (phase == PH_LAST) begin
                  phase <= '0;
                  sck   <= 1'b1;
                  state <= S_SHIFT;
               end else begin
                  phase <= phase + 8'd1;
               end
            end

            S_SHIFT: begin
               if (phase != PH_LAST) begin
                  phase <= phase + 8'd1;
               end else begin
                  phase <= '0;
                  if (sck) begin
                     // Falling edge: present the next bit, or idle sdo during the CS hold phase.
                     sck <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        sdo <= 1'b0;
                     end else begin
                        sdo   <= shreg[14];
                        shreg <= {shreg[13:0], 1'b0};
                     end
                  end else if (bit_cnt == BIT_LAST) begin
                     state   <= S_GAP;
                     chip_en <= 1'b1;
                     done    <= ONE_CYC && !HAS_LATCH;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     sck     <= 1'b1;
                  end
               end
            end

            S_GAP: begin
               if (phase == PH_LAST) begin
                  phase <= '0;
`ifdef DAC_SPI_TX_LDAC_EN
                  state <= S_LATCH;
                  ldac  <= 1'b0;
                  done  <= ONE_CYC;
`else
                  state <= S_IDLE;
                  ready <= 1'b1;
`endif
               end else begin
                  phase <= phase + 8'd1;
                  done  <= !HAS_LATCH && (phase == PH_PRE);
               end
            end

`ifdef DAC_SPI_TX_LDAC_EN
            S_LATCH: begin
               if (phase == PH_LAST) begin
                  phase <= '0;
                  state <= S_IDLE;
                  ready <= 1'b1;
                  ldac  <= 1'b1;
               end else begin
                  phase <= phase + 8'd1;
                  done  <= (phase == PH_PRE);
               end
            end
`endif

            default: begin
               state   <= S_IDLE;
               ready   <= 1'b1;
               chip_en <= 1'b1;
               sck     <= 1'b0;
               sdo     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
SPI transmitter that drives an external MCP4921-style 12-bit DAC. It pairs with the ADC SPI receive path: samples read from the ADC are processed and the results are written back out through this block. It accepts a 12-bit sample on a valid/ready handshake and prepends 4 DAC configuration bits. It then shifts out one 16-bit SPI mode-0 frame (MSB first) with a generated sck and chip_en, and reports completion.

Parameters:
CLK_DIV, 4, clk cycles per sck half-period (legal range 1..255).
BUF, 0, value of DAC config bit 14 (VREF buffer).
GAIN1X, 1, value of DAC config bit 13 (GA_n; 1 selects 1x gain).

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to send a frame; sampled only while ready=1
data_in  input  12  DAC code; captured in the acceptance cycle
ready  output  1  1 = idle and able to accept start
done  output  1  one-cycle pulse when a frame completes
sck  output  1  SPI clock to DAC; idle low (mode 0)
sdo  output  1  SPI data to DAC; changes while sck is low
chip_en  output  1  DAC chip-select pin level; active-low, idle 1

Behaviour:
- Reset values (applied asynchronously while reset=1): state=IDLE, ready=1, done=0, sck=0, sdo=0, chip_en=1, all counters 0.
- A reset asserted mid-frame aborts the frame immediately. No done pulse is produced.
- Frame word is {1'b0 (channel A), BUF, GAIN1X, 1'b1 (SHDN_n active), data_in[11:0]}, sent MSB first.
- Acceptance: start=1 and ready=1 at a rising edge. This is cycle 0.
  - The frame word is latched into a 16-bit shift register.
  - ready drops to 0 in cycle 1.
  - start is ignored while ready=0.
  - data_in changes after cycle 0 have no effect on the frame in flight.
- States: IDLE -> SETUP -> SHIFT -> GAP -> IDLE. Cycle numbering below uses D = CLK_DIV.
  - SETUP, cycles 1..D: chip_en=0, sck=0, sdo=bit15.
  - SHIFT, cycles D+1..33D: 16 bit periods of 2D cycles each, high phase first.
    - sck=1 for D cycles, then sck=0 for D cycles.
    - sdo advances to the next bit at the start of each low phase, giving the DAC D cycles of setup before its rising-edge sample.
    - After the 16th bit's low phase (the chip-select hold time), sdo=0.
    - A bit counter (0..15) and a phase counter (0..D-1) control this state.
  - GAP, cycles 33D+1..34D: chip_en=1, sck=0, sdo=0. Provides the minimum chip-select high time.
  - done=1 in cycle 34D only.
  - IDLE: ready=1 from cycle 34D+1.
- Frame length from acceptance to ready: exactly 34D+1 cycles. Exactly 16 sck rising edges per frame.
- Back-to-back operation: if start is held at 1, a new frame is accepted in the first cycle with ready=1. Within that cycle chip_en stays 1, so consecutive frames are separated by at least D+1 cycles of chip_en=1.
- sck, sdo and chip_en are driven directly from flops, giving glitch-free pins.
- The phase counter width is 8 bits; values of CLK_DIV outside 1..255 are unsupported.

Optional Feature:
- Macro: DAC_SPI_TX_LDAC_EN.
- Defined:
  - An extra output port ldac (1 bit, active-low, reset value 1) is present.
  - A LATCH state is inserted after GAP. ldac=0 for exactly D cycles, then returns to 1.
  - done pulses in the last LATCH cycle. Frame length becomes 35D+1 cycles.
  - A reset during LATCH forces ldac=1 immediately.
- Undefined:
  - No ldac port and no LATCH state. The DAC's LDAC pin is tied low on the board, so output updates on the chip_en rising edge.
  - Timing is exactly as in Behaviour.

Test Plan:
- Reset then idle, CLK_DIV=4: after reset release and 50 idle cycles -> ready=1, chip_en=1, sck=0, sdo=0, done=0 throughout.
- Single frame, data_in=0xABC, BUF=0, GAIN1X=1, D=4 -> 16 bits captured on sck rising edges equal 0x3ABC; chip_en low for cycles 1..132; done=1 at cycle 136; ready=1 at cycle 137.
- Handshake robustness: start pulsed at cycles 5 and 60 of a frame, data_in changed to 0x555 mid-frame -> both pulses ignored, frame content unchanged, exactly 16 sck rising edges.
- Back-to-back, start held high, data 0x000 then 0xFFF, D=1 -> frames 0x3000 and 0x3FFF; chip_en high for at least 2 cycles between frames; done pulses 35 cycles apart.
- Reset mid-frame: reset asserted at cycle 70 for 3 cycles -> chip_en=1, sck=0, sdo=0 in the same cycle (async); no done pulse; next frame with 0x123 sends 0x3123 correctly.
- With DAC_SPI_TX_LDAC_EN defined, D=4, data 0x800 -> ldac=0 for cycles 137..140 only; done=1 at cycle 140; ready=1 at cycle 141.
